// File: rtl/reg_bank.sv
// reg_bank: write-back register file with bypassed read ports
// and a per-register pending-write scoreboard for operand stalls.
module reg_bank #(
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   in_WB,
  input  logic          W_RB,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [31:0]   out_A,
  output logic [31:0]   out_B,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  output logic          stall,
  output logic          waw_err
);

  localparam logic Z0 = (ZERO_R0 != 0);

  logic [31:0]     r_regs [NREG];
  logic [NREG-1:0] r_pend;

  logic            w_wr_ok;
  logic            w_hit_a;
  logic            w_hit_b;
  logic            w_hit_i;
  logic            w_z_a;
  logic            w_z_b;
  logic            w_z_i;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_one;

  assign w_one   = {{(NREG-1){1'b0}}, 1'b1};
  assign w_z_a   = Z0 && (rd_addr_a == '0);
  assign w_z_b   = Z0 && (rd_addr_b == '0);
  assign w_z_i   = Z0 && (iss_addr == '0);
  assign w_wr_ok = W_RB && !(Z0 && (wr_addr == '0));
  assign w_hit_a = W_RB && (wr_addr == rd_addr_a);
  assign w_hit_b = W_RB && (wr_addr == rd_addr_b);
  assign w_hit_i = W_RB && (wr_addr == iss_addr);

  // register file write; a write in a reset cycle is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= in_WB;
    end
  end

  // scoreboard set/clear masks; r0 is never marked when hardwired
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid && !w_z_i) w_set = w_one << iss_addr;
    if (W_RB) w_clr = w_one << wr_addr;
  end

  // pending bits: a new issue outranks a same-cycle write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_set | (r_pend & ~w_clr);
  end

  // read port A with r0 hardwire and write-through bypass
  always_comb begin
    out_A = r_regs[rd_addr_a];
    if (w_z_a)        out_A = '0;
    else if (w_hit_a) out_A = in_WB;
    if (!rst_n)       out_A = '0;
  end

  // read port B with r0 hardwire and write-through bypass
  always_comb begin
    out_B = r_regs[rd_addr_b];
    if (w_z_b)        out_B = '0;
    else if (w_hit_b) out_B = in_WB;
    if (!rst_n)       out_B = '0;
  end

  // stall on a pending operand not served by the bypass this cycle
  always_comb begin
    stall = (r_pend[rd_addr_a] && !w_hit_a)
         || (r_pend[rd_addr_b] && !w_hit_b);
  end

  // flag an issue onto a register whose producer is still outstanding
  always_comb begin
    waw_err = iss_valid && r_pend[iss_addr] && !w_hit_i && !w_z_i;
  end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: table-driven directed vectors for reg_bank
// plus a hand-written asynchronous reset sequence.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_WB;
  logic        W_RB;
  logic [3:0]  wr_addr;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [31:0] out_A;
  logic [31:0] out_B;
  logic        iss_valid;
  logic [3:0]  iss_addr;
  logic        stall;
  logic        waw_err;

  int checks = 0;
  int errors = 0;

  reg_bank #(.NREG(16), .AW(4), .ZERO_R0(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_WB(in_WB), .W_RB(W_RB),
    .wr_addr(wr_addr), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .out_A(out_A), .out_B(out_B),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .stall(stall), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    bit          iv;
    logic [3:0]  ia;
    logic [31:0] ea;
    logic [31:0] eb;
    bit          es;
    bit          ew;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    bit rst, bit we, logic [3:0] wa, logic [31:0] wd,
    logic [3:0] ra, logic [3:0] rb, bit iv, logic [3:0] ia,
    logic [31:0] ea, logic [31:0] eb, bit es, bit ew);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.ra = ra; v.rb = rb; v.iv = iv; v.ia = ia;
    v.ea = ea; v.eb = eb; v.es = es; v.ew = ew;
    return v;
  endfunction

  task automatic chk(string nm, int idx,
                     logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst_n     = !v.rst;
    W_RB      = v.we;
    wr_addr   = v.wa;
    in_WB     = v.wd;
    rd_addr_a = v.ra;
    rd_addr_b = v.rb;
    iss_valid = v.iv;
    iss_addr  = v.ia;
  endtask

  initial begin
    rst_n = 1'b0; W_RB = 1'b0; wr_addr = '0; in_WB = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    iss_valid = 1'b0; iss_addr = '0;

    //        rst we wa  wd            ra rb iv ia  ea            eb            es ew
    vq.push_back(mk(0,1, 3,32'hDEADBEEF, 3, 0, 0, 0,32'hDEADBEEF,32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        3, 0, 1, 3,32'hDEADBEEF,32'h0,       0,0));
    vq.push_back(mk(1,1, 3,32'h11111111, 3, 0, 0, 0,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        3, 3, 0, 0,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,1, 5,32'hFFFF0000, 0, 0, 0, 0,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,1, 6,32'h0000FFFF, 0, 0, 0, 0,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        5, 6, 0, 0,32'hFFFF0000,32'h0000FFFF,0,0));
    vq.push_back(mk(0,1, 7,32'h12345678, 7, 0, 0, 0,32'h12345678,32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        7, 0, 0, 0,32'h12345678,32'h0,       0,0));
    vq.push_back(mk(0,1, 0,32'hFFFFFFFF, 0, 0, 1, 0,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        0, 0, 1, 0,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        0, 0, 0, 0,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        0, 0, 1, 4,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        4, 0, 0, 0,32'h0,       32'h0,       1,0));
    vq.push_back(mk(0,0, 0,32'h0,        4, 0, 0, 0,32'h0,       32'h0,       1,0));
    vq.push_back(mk(0,0, 0,32'h0,        4, 0, 0, 0,32'h0,       32'h0,       1,0));
    vq.push_back(mk(0,1, 4,32'hAAAA5555, 4, 0, 0, 0,32'hAAAA5555,32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        4, 0, 0, 0,32'hAAAA5555,32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        0, 0, 1, 9,32'h0,       32'h0,       0,0));
    vq.push_back(mk(0,1, 9,32'h00000099, 9, 0, 1, 9,32'h00000099,32'h0,       0,0));
    vq.push_back(mk(0,0, 0,32'h0,        9, 0, 0, 0,32'h00000099,32'h0,       1,0));
    vq.push_back(mk(0,0, 0,32'h0,        9, 0, 1, 9,32'h00000099,32'h0,       1,1));
    vq.push_back(mk(0,0, 0,32'h0,        0, 9, 0, 0,32'h0,       32'h00000099,1,0));
    vq.push_back(mk(0,1, 9,32'h00000055, 0, 9, 0, 0,32'h0,       32'h00000055,0,0));
    vq.push_back(mk(0,0, 0,32'h0,        0, 9, 1, 9,32'h0,       32'h00000055,0,0));

    #2;
    chk("rst_outA",  -1, out_A,   32'h0);
    chk("rst_outB",  -1, out_B,   32'h0);
    chk("rst_stall", -1, 32'(stall),   32'h0);
    chk("rst_waw",   -1, 32'(waw_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #2;
      chk("outA",  i, out_A, vq[i].ea);
      chk("outB",  i, out_B, vq[i].eb);
      chk("stall", i, 32'(stall),   32'(vq[i].es));
      chk("waw",   i, 32'(waw_err), 32'(vq[i].ew));
    end

    // pending r2, then async reset mid-cycle drops the stall at once
    @(negedge clk);
    drive(mk(0,0,0,32'h0,0,0,1,2,32'h0,32'h0,0,0));
    @(negedge clk);
    drive(mk(0,0,0,32'h0,2,0,1,2,32'h0,32'h0,0,0));
    #2;
    chk("seq_stall", 0, 32'(stall),   32'h1);
    chk("seq_waw",   0, 32'(waw_err), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("seq_rst_stall", 1, 32'(stall),   32'h0);
    chk("seq_rst_waw",   1, 32'(waw_err), 32'h0);
    @(negedge clk);
    drive(mk(0,0,0,32'h0,2,2,0,0,32'h0,32'h0,0,0));
    #2;
    chk("seq_post_stall", 2, 32'(stall), 32'h0);
    chk("seq_post_outA",  2, out_A,      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Register bank for the processor write-back stage. It sits directly downstream of the write-back source mux and consumes that mux's 32-bit output as write data.
- Provides two combinational read ports with write-through bypass for the operand-fetch stage.
- Holds a per-register pending-write scoreboard. Issue logic marks a destination register busy; the bank raises a stall when an operand is still in flight.

Parameters:
- NREG, 16, number of registers (power of two, 4..32).
- AW, 4, address width; must equal log2(NREG).
- ZERO_R0, 1, when 1 register 0 reads as zero and ignores writes and issue marks.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_WB  input  32  write-back data from the write-back source mux.
- W_RB  input  1  write enable for the write-back port.
- wr_addr  input  AW  write-back destination register.
- rd_addr_a  input  AW  read port A address.
- rd_addr_b  input  AW  read port B address.
- out_A  output  32  read port A data.
- out_B  output  32  read port B data.
- iss_valid  input  1  an instruction with a destination register is issuing this cycle.
- iss_addr  input  AW  destination register of the issuing instruction.
- stall  output  1  an operand is pending and not available this cycle.
- waw_err  output  1  issue targets a register that is already pending.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0; all pending bits 0. Outputs follow combinationally: out_A = out_B = 0, stall = 0, waw_err = 0. Reset asserted mid-operation discards any write in that cycle; release is synchronous to clk.
- Write: on rising clk with W_RB=1, reg[wr_addr] <= in_WB. With ZERO_R0=1 and wr_addr=0 the write is dropped.
- Read: combinational with zero latency. out_A = reg[rd_addr_a], except:
  - If ZERO_R0=1 and rd_addr_a=0, out_A = 0.
  - Otherwise, if W_RB=1 and wr_addr=rd_addr_a, out_A = in_WB (write-through bypass).
  - out_B follows the same rules on rd_addr_b.
- Scoreboard, per register i, updated at rising clk:
  - Set when iss_valid=1 and iss_addr=i.
  - Cleared when W_RB=1 and wr_addr=i.
  - Set and clear in the same cycle on the same register: set wins, because the new producer stays outstanding.
  - With ZERO_R0=1, bit 0 is never set.
- Stall (combinational): stall=1 when, for either read port, pend[rd_addr]=1 and NOT (W_RB=1 and wr_addr=rd_addr). A pending register being written back this cycle is served by the bypass and does not stall. Both read ports are always evaluated; there is no per-port use flag, so issue logic must point an unused port at register 0.
- waw_err (combinational): 1 when iss_valid=1, pend[iss_addr]=1, the register is not being cleared this cycle, and the register is not r0 with ZERO_R0=1. The bank does not block the issue. The pending bit simply stays set, and the first write-back clears it.
- Out-of-range addresses cannot occur because NREG = 2^AW.
- There are no other internal states. The bank accepts one write and one issue per cycle with no back-pressure of its own.

Test Plan:
- Reset then read: assert rst_n=0 mid-cycle with a prior value 0xDEADBEEF in r3; read r3 -> out_A=0 immediately, stall=0, all pend=0.
- Write/read: write 0xFFFF0000 to r5 and 0x0000FFFF to r6 on consecutive cycles. Next cycle read A=r5, B=r6 -> out_A=0xFFFF0000, out_B=0x0000FFFF.
- Bypass: W_RB=1, wr_addr=7, in_WB=0x12345678, rd_addr_a=7 in the same cycle -> out_A=0x12345678 before the clock edge. After the edge, W_RB=0 -> still 0x12345678.
- r0 hardwire: write 0xFFFFFFFF to r0 and issue r0 -> out_A(r0)=0 both during and after the write, pend[0]=0, stall=0, waw_err=0.
- Scoreboard stall: issue r4, then next cycle read r4 -> stall=1. Keep reading for 3 cycles -> stall stays 1. Write back 0xAAAA5555 to r4 -> stall=0 in that cycle with out_A=0xAAAA5555. Following cycle pend[4]=0.
- Simultaneous set/clear plus WAW: pend[9]=1; in one cycle issue r9 and write back r9 -> waw_err=0 and pend[9] stays 1. Then issue r9 again with no write back -> waw_err=1.
